// File: rtl/mac_rx_fcs_check_pkg.sv
// Shared types, constants and CRC-32 helpers for the MAC RX FCS checker.
package mac_rx_fcs_check_pkg;

  localparam int unsigned N_SYMBOLS = 4;
  localparam int unsigned W_SYMBOL  = 8;
  localparam int unsigned W_DATA    = N_SYMBOLS * W_SYMBOL;
  localparam int unsigned W_CRC     = 32;
  localparam int unsigned W_POP     = $clog2(N_SYMBOLS + 1);

  localparam logic [W_CRC-1:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [W_CRC-1:0] CRC_RESET   = 32'hFFFFFFFF;
  localparam logic [W_CRC-1:0] CRC_RESIDUE = 32'hC704DD7B;

  localparam int unsigned DEF_MIN_FRAME_LEN = 64;
  localparam int unsigned DEF_MAX_FRAME_LEN = 1518;
  localparam int unsigned DEF_W_LEN         = 16;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } rx_state_t;

  typedef struct packed {
    logic crc_err;
    logic len_err;
    logic abort;
  } stat_flags_t;

  // MSB-first register, each byte fed LSB first (Ethernet wire order)
  function automatic logic [W_CRC-1:0] calc_crc_8bit(input logic [W_CRC-1:0] crc,
                                                     input logic [W_SYMBOL-1:0] d);
    logic [W_CRC-1:0] c;
    c = crc;
    for (int i = 0; i < int'(W_SYMBOL); i++) begin
      c = (c[W_CRC-1] ^ d[i]) ? ({c[W_CRC-2:0], 1'b0} ^ CRC_POLY) : {c[W_CRC-2:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [W_CRC-1:0] calc_crc_16bit(input logic [W_CRC-1:0] crc,
                                                      input logic [15:0] d);
    return calc_crc_8bit(calc_crc_8bit(crc, d[7:0]), d[15:8]);
  endfunction

  function automatic logic [W_CRC-1:0] calc_crc_24bit(input logic [W_CRC-1:0] crc,
                                                      input logic [23:0] d);
    return calc_crc_8bit(calc_crc_16bit(crc, d[15:0]), d[23:16]);
  endfunction

  function automatic logic [W_CRC-1:0] calc_crc_32bit(input logic [W_CRC-1:0] crc,
                                                      input logic [31:0] d);
    return calc_crc_8bit(calc_crc_24bit(crc, d[23:0]), d[31:24]);
  endfunction

  function automatic logic [W_POP-1:0] popcount(input logic [N_SYMBOLS-1:0] m);
    logic [W_POP-1:0] n;
    n = '0;
    for (int i = 0; i < int'(N_SYMBOLS); i++) n = n + W_POP'(m[i]);
    return n;
  endfunction

  // Legal masks fill lanes from lane 0 upward with no holes
  function automatic logic mask_ok(input logic [N_SYMBOLS-1:0] m);
    return m[0] && ((m & (m + N_SYMBOLS'(1))) == '0);
  endfunction

  function automatic logic [W_CRC-1:0] crc_update(input logic [W_CRC-1:0] crc,
                                                  input logic [W_DATA-1:0] d,
                                                  input logic [N_SYMBOLS-1:0] m);
    logic [W_CRC-1:0] r;
    case (popcount(m))
      W_POP'(1): r = calc_crc_8bit(crc, d[7:0]);
      W_POP'(2): r = calc_crc_16bit(crc, d[15:0]);
      W_POP'(3): r = calc_crc_24bit(crc, d[23:0]);
      default:   r = calc_crc_32bit(crc, d[31:0]);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mac_rx_fcs_check_strip.sv
// One-word hold register that drops the trailing FCS bytes from the forwarded stream.
// MAC_RX_FCS_PASS_EN selects a plain one-cycle pass-through that keeps the FCS.
module mac_rx_fcs_check_strip
  import mac_rx_fcs_check_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_take,
  input  logic                 i_bad,
  input  logic [N_SYMBOLS-1:0] i_valid,
  input  logic [W_DATA-1:0]    i_data,
  input  logic                 i_sof,
  input  logic                 i_eof,
  output logic [N_SYMBOLS-1:0] o_valid,
  output logic [W_DATA-1:0]    o_data,
  output logic                 o_sof,
  output logic                 o_eof
);

`ifdef MAC_RX_FCS_PASS_EN

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid <= '0;
      o_data  <= '0;
      o_sof   <= 1'b0;
      o_eof   <= 1'b0;
    end else begin
      o_valid <= i_take ? i_valid : '0;
      o_sof   <= i_take & i_sof;
      o_eof   <= i_take & (i_eof | i_bad);
      if (i_take) o_data <= i_data;
    end
  end

`else

  logic [W_DATA-1:0]    hold_q;
  logic                 hold_full_q;
  logic                 sof_pend_q;
  logic                 emit_c;
  logic                 close_c;
  logic                 store_c;
  logic [N_SYMBOLS-1:0] mask_c;

  // A taken word always pushes out a full H; eof/abort also closes the frame
  always_comb begin
    emit_c  = i_take & hold_full_q;
    close_c = i_eof | i_bad | (i_sof & hold_full_q);
    store_c = i_take & ~i_eof & ~i_bad;
    mask_c  = (i_eof & ~i_bad & ~i_sof) ? i_valid : '1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sof_pend_q  <= 1'b0;
      o_valid     <= '0;
      o_data      <= '0;
      o_sof       <= 1'b0;
      o_eof       <= 1'b0;
    end else begin
      o_valid <= emit_c ? mask_c : '0;
      o_sof   <= emit_c & sof_pend_q;
      o_eof   <= emit_c & close_c;
      if (emit_c) o_data <= hold_q;
      if (store_c) begin
        hold_q      <= i_data;
        hold_full_q <= 1'b1;
        sof_pend_q  <= i_sof;
      end else if (i_take) begin
        hold_full_q <= 1'b0;
        sof_pend_q  <= 1'b0;
      end
    end
  end

`endif

endmodule

// File: rtl/mac_rx_fcs_check.sv
// RX FCS checker: CRC-32 residue and length check with FCS strip and end-of-frame status.
// Build option MAC_RX_FCS_PASS_EN forwards the FCS instead of stripping it.
module mac_rx_fcs_check
  import mac_rx_fcs_check_pkg::*;
#(
  parameter int unsigned MIN_FRAME_LEN = DEF_MIN_FRAME_LEN,
  parameter int unsigned MAX_FRAME_LEN = DEF_MAX_FRAME_LEN,
  parameter int unsigned W_LEN         = DEF_W_LEN
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_clk_en,
  input  logic [N_SYMBOLS-1:0]          i_valid,
  input  logic [N_SYMBOLS*W_SYMBOL-1:0] i_data,
  input  logic                          i_sof,
  input  logic                          i_eof,
  output logic [N_SYMBOLS-1:0]          o_valid,
  output logic [N_SYMBOLS*W_SYMBOL-1:0] o_data,
  output logic                          o_sof,
  output logic                          o_eof,
  output logic                          o_stat_valid,
  output logic                          o_stat_crc_err,
  output logic                          o_stat_len_err,
  output logic                          o_stat_abort,
  output logic [W_LEN-1:0]              o_frame_len
);

  rx_state_t        state_q, state_d;
  logic [W_CRC-1:0] crc_q, crc_d;
  logic [W_LEN-1:0] len_q, len_d;
  logic [W_LEN-1:0] len_base_c;
  logic [W_LEN:0]   len_sum_c;
  logic [W_LEN-1:0] stat_len_c;
  logic             accept_c;
  logic             take_c;
  logic             bad_c;
  logic             in_frame_c;
  logic             stat_fire_c;
  stat_flags_t      flags_c;

  // Next state, running CRC/length and end-of-frame status
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    len_d       = len_q;
    stat_fire_c = 1'b0;
    flags_c     = '0;
    stat_len_c  = len_q;

    in_frame_c = (state_q == ST_IN_FRAME);
    accept_c   = i_clk_en & (|i_valid);
    bad_c      = ~mask_ok(i_valid) | (~i_eof & (i_valid != '1));
    take_c     = accept_c & (i_sof | in_frame_c);
    len_base_c = i_sof ? '0 : len_q;
    len_sum_c  = {1'b0, len_base_c} + (W_LEN+1)'(popcount(i_valid));

    if (take_c) begin
      crc_d       = crc_update(i_sof ? CRC_RESET : crc_q, i_data, i_valid);
      len_d       = len_sum_c[W_LEN] ? '1 : len_sum_c[W_LEN-1:0];
      stat_fire_c = i_eof | bad_c | (i_sof & in_frame_c);
      if (bad_c || (i_sof && in_frame_c)) begin
        // Aborted frame reports the bytes it had before the terminating word
        flags_c.abort = 1'b1;
        stat_len_c    = in_frame_c ? len_q : '0;
      end else begin
        flags_c.crc_err = (crc_d != CRC_RESIDUE);
        flags_c.len_err = (len_d < W_LEN'(MIN_FRAME_LEN)) ||
                          (len_d > W_LEN'(MAX_FRAME_LEN)) || (len_d == '1);
        stat_len_c      = len_d;
      end
      state_d = (bad_c || i_eof) ? ST_IDLE : ST_IN_FRAME;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q        <= ST_IDLE;
      crc_q          <= CRC_RESET;
      len_q          <= '0;
      o_stat_valid   <= 1'b0;
      o_stat_crc_err <= 1'b0;
      o_stat_len_err <= 1'b0;
      o_stat_abort   <= 1'b0;
      o_frame_len    <= '0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      len_q        <= len_d;
      o_stat_valid <= stat_fire_c;
      if (stat_fire_c) begin
        o_stat_crc_err <= flags_c.crc_err;
        o_stat_len_err <= flags_c.len_err;
        o_stat_abort   <= flags_c.abort;
        o_frame_len    <= stat_len_c;
      end
    end
  end

  mac_rx_fcs_check_strip u_strip (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_take    (take_c),
    .i_bad     (bad_c),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .i_sof     (i_sof),
    .i_eof     (i_eof),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_sof     (o_sof),
    .o_eof     (o_eof)
  );

endmodule

// File: doc/mac_rx_fcs_check.md
Name: mac_rx_fcs_check

Overview:
Receive-side FCS checker for the MAC. It consumes the 4-lane RX byte stream from the PCS, with frame delimiters and the 4-byte FCS still attached. It runs CRC-32 over every byte including the FCS, strips the FCS from the forwarded stream, and at end of frame reports CRC, length and framing status to the RX MAC FSM and statistics logic.

Parameters:
MIN_FRAME_LEN, 64, minimum legal frame length in bytes including FCS
MAX_FRAME_LEN, 1518, maximum legal frame length in bytes including FCS
W_LEN, 16, width of the byte counter; the counter saturates at 2**W_LEN-1

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_clk_en  in  1  clock enable; no state changes while low
i_valid  in  N_SYMBOLS  per-lane byte valid; contiguous from lane 0
i_data  in  N_SYMBOLS*W_SYMBOL  lane 0 carries the earliest byte
i_sof  in  1  first word of frame
i_eof  in  1  last word of frame (its mask may be partial)
o_valid  out  N_SYMBOLS  forwarded lane valid
o_data  out  N_SYMBOLS*W_SYMBOL  forwarded data
o_sof  out  1  first forwarded word
o_eof  out  1  last forwarded word
o_stat_valid  out  1  one-cycle status strobe
o_stat_crc_err  out  1  residue mismatch
o_stat_len_err  out  1  runt or oversize frame
o_stat_abort  out  1  frame terminated by a new sof, or invalid lane mask
o_frame_len  out  W_LEN  byte count including FCS

Behaviour:
- Reset: i_reset_n is asynchronous and active-low. Every output is 0; state is IDLE; the hold register is empty; the CRC register is CRC_RESET; the counter is 0.
- An input word is accepted when i_clk_en=1 and i_valid!=0.
- FSM IDLE:
  - A word accepted without i_sof is dropped.
  - i_sof moves the FSM to IN_FRAME.
- FSM IN_FRAME:
  - i_eof (or abort) returns the FSM to IDLE.
- CRC:
  - On sof the CRC register is seeded with CRC_RESET, then updated with the sof word's bytes in the same cycle.
  - Update uses the package calc_crc_8/16/24/32bit functions, selected by the i_valid mask.
  - The frame is good when the register value after the eof word equals CRC_RESIDUE.
- Length: the counter adds popcount(i_valid) per accepted word and restarts at sof.
- FCS strip uses a one-word hold register H:
  - Non-eof word: if H is full, H goes to the output with its full mask; the incoming word is stored in H.
  - eof word with k valid lanes: it contains only FCS bytes and is discarded. H goes to the output with o_valid=i_valid (lower k lanes), o_eof=1, and o_stat_valid=1 in the same cycle. H is then emptied.
  - o_sof accompanies the first forwarded word.
  - A forwarded word appears the cycle after the next word of the same frame is accepted.
  - All outputs are registered. o_valid, o_sof, o_eof and o_stat_valid are 1-cycle pulses.
- Status on eof:
  - o_stat_crc_err is set on residue mismatch.
  - o_stat_len_err is set when the length is below MIN_FRAME_LEN or above MAX_FRAME_LEN.
  - o_frame_len is valid while o_stat_valid=1.
- Boundary conditions:
  - sof and eof in the same word (frame of 4 bytes or fewer): no data is output; the status strobe alone fires with len_err=1.
  - sof while IN_FRAME: H is flushed with o_eof=1 and status abort=1. The new frame starts in the same cycle.
  - Non-contiguous mask, or a partial mask without eof: abort=1, and the frame is closed as for sof while IN_FRAME. The FSM moves to IDLE.
  - i_clk_en low: everything holds, and output strobes stay low.
  - Counter saturates; a saturated count gives len_err=1.
  - Reset mid-frame: the frame is discarded and no status is emitted.

Optional Feature:
MAC_RX_FCS_PASS_EN
- Defined: the FCS is not stripped. The output is the accepted input delayed one cycle with its original mask, sof and eof. The status strobe coincides with o_eof. The CRC and length checks are unchanged.
- Undefined: strip behaviour as specified above.

Decomposition:
- mac_params additions: CRC_RESIDUE (32'hC704DD7B, raw register form matching the calc functions); MIN/MAX frame length defaults; a typedef for the status struct (crc_err, len_err, abort, len).
- Existing package items reused: calc_crc_* functions, CRC_RESET, N_SYMBOLS, W_SYMBOL, W_CRC.
- One sub-module, mac_rx_fcs_strip: hold register H plus eof lane trimming, with the pass-through variant under the macro.

Test Plan:
1. Good frame, ASCII "123456789" followed by FCS 26 39 F4 CB (13 bytes), sent as words 31-34, 35-38, 39 26 39 F4, then CB with mask 0001 and eof.
   -> Output: two full words, then 0x39 with mask 0001 and eof; crc_err=0, len_err=1, len=13.
2. 64-byte frame with correct FCS (full eof mask).
   -> 15 forwarded words, last one full with eof; all status 0; len=64.
3. Same frame with payload byte 10 flipped.
   -> crc_err=1, len_err=0; data forwarded unchanged.
4. sof at word 5 of an open frame.
   -> Previous H forwarded with eof, abort=1; the new frame completes normally.
5. i_clk_en toggled 50% during test 2.
   -> Identical output sequence, stretched in time.
6. Reset asserted mid-frame, then a good frame.
   -> No status for the aborted frame; the second frame reports clean status.
